// File: rtl/nonce_transmitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nonce_transmitter: serializes a captured nonce LSB-first onto a byte     |
// | valid/ready stream. Option macro: NONCE_TX_CHECKSUM_EN (XOR trailer).    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module nonce_transmitter #(
  parameter int NONCE_WIDTH = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   send_i,
  input  logic [NONCE_WIDTH-1:0] nonce_i,
  input  logic                   tx_ready_i,
  output logic                   tx_valid_o,
  output logic [7:0]             tx_data_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int NUM_BYTES = NONCE_WIDTH / 8;
  localparam int c_CNT_W   = $clog2(NUM_BYTES + 1);
  localparam logic [c_CNT_W-1:0] c_LAST_NONCE_IDX = c_CNT_W'(NUM_BYTES - 1);
`ifdef NONCE_TX_CHECKSUM_EN
  localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(NUM_BYTES);
`else
  localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(NUM_BYTES - 1);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [NONCE_WIDTH-1:0] r_shift, w_shift_nxt;
  logic [c_CNT_W-1:0]     r_count, w_count_nxt;
  logic                   r_done;
`ifdef NONCE_TX_CHECKSUM_EN
  logic [7:0]             r_csum, w_csum_nxt;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_count <= w_count_nxt;
      r_done  <= (r_state == DONE);
    end
  end

`ifdef NONCE_TX_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_csum <= '0;
    end else begin
      r_csum <= w_csum_nxt;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_count_nxt = r_count;
`ifdef NONCE_TX_CHECKSUM_EN
    w_csum_nxt  = r_csum;
`endif
    case (r_state)
      IDLE: begin
        if (send_i) begin
          w_state_nxt = SEND;
          w_shift_nxt = nonce_i;
          w_count_nxt = '0;
`ifdef NONCE_TX_CHECKSUM_EN
          w_csum_nxt  = '0;
`endif
        end
      end
      SEND: begin
        if (tx_ready_i) begin
          w_shift_nxt = r_shift >> 8;
`ifdef NONCE_TX_CHECKSUM_EN
          w_csum_nxt  = r_csum ^ r_shift[7:0];
          // The trailer byte rides the same shift path once the nonce is drained.
          if (r_count == c_LAST_NONCE_IDX) begin
            w_shift_nxt = NONCE_WIDTH'(r_csum ^ r_shift[7:0]);
          end
`endif
          if (r_count == c_LAST_IDX) begin
            w_state_nxt = DONE;
          end else begin
            w_count_nxt = r_count + 1'b1;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Decoded from the async-reset state register so valid drops with reset.
  assign tx_valid_o = (r_state == SEND);
  assign busy_o     = (r_state == SEND);
  assign tx_data_o  = r_shift[7:0];
  assign done_o     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_nonce_transmitter.sv
`default_nettype none
// Scoreboard bench for nonce_transmitter: driver queues expected bytes, monitor
// pops them on each accepted transfer; a 16-bit instance covers the narrow case.
module tb_nonce_transmitter;

  localparam int NW = 256;
  localparam int NB = NW / 8;
`ifdef NONCE_TX_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          send = 1'b0;
  logic [NW-1:0] nonce = '0;
  logic          tx_ready = 1'b1;
  logic          tx_valid, busy, done;
  logic [7:0]    tx_data;

  logic          send16 = 1'b0;
  logic [15:0]   nonce16 = '0;
  logic          ready16 = 1'b1;
  logic          valid16, busy16, done16;
  logic [7:0]    data16;

  always #5 clk = ~clk;

  nonce_transmitter #(.NONCE_WIDTH(NW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .send_i(send), .nonce_i(nonce),
    .tx_ready_i(tx_ready), .tx_valid_o(tx_valid), .tx_data_o(tx_data),
    .busy_o(busy), .done_o(done)
  );

  nonce_transmitter #(.NONCE_WIDTH(16)) dut16 (
    .clk_i(clk), .rst_n_i(rst_n), .send_i(send16), .nonce_i(nonce16),
    .tx_ready_i(ready16), .tx_valid_o(valid16), .tx_data_o(data16),
    .busy_o(busy16), .done_o(done16)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  byte unsigned exp_q[$];
  int  xfers = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  bit  done_pending = 1'b0;
  int  ready_mode = 0;
  int  pat_idx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ready pattern driver: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = random.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: tx_ready = 1'b1;
      1: begin
        tx_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
        pat_idx++;
      end
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: transfers, stall stability and done strobes.
  initial begin
    bit         stalled;
    logic [7:0] prev_data;
    byte unsigned e;
    stalled = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        check("stall_valid_held", 64'(tx_valid), 64'd1);
        check("stall_data_held", 64'(tx_data), 64'(prev_data));
      end
      stalled   = tx_valid && !tx_ready;
      prev_data = tx_data;
      if (tx_valid && tx_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL byte_unexpected: got 0x%0h, expected no transfer (cycle %0d)", tx_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("byte", 64'(tx_data), 64'(e));
        end
      end
      if (done) begin
        check("done_expected", {62'd0, done_pending, exp_q.size() == 0}, 64'd3);
        check("busy_low_at_done", 64'(busy), 64'd0);
        done_pending = 1'b0;
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_msg(input logic [NW-1:0] n, input int mode, output int t0);
    logic [7:0] x;
    @(posedge clk);
    #2;
    ready_mode = mode;
    pat_idx = 0;
    send  = 1'b1;
    nonce = n;
    x = '0;
    for (int k = 0; k < NB; k++) begin
      exp_q.push_back(n[8*k +: 8]);
      x ^= n[8*k +: 8];
    end
    if (EXTRA == 1) exp_q.push_back(x);
    done_pending = 1'b1;
    xfers = 0;
    t0 = cyc;
    @(posedge clk);
    #2;
    send  = 1'b0;
    nonce = {8{$urandom()}};
  endtask

  task automatic finish_msg(input int t0, input bit chk_lat);
    int guard;
    guard = 0;
    while (done_pending && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check("done_timeout", 64'(done_pending), 64'd0);
    if (chk_lat) check("done_latency", 64'(done_cyc - t0), 64'(NB + 2 + EXTRA));
    check("bytes_sent", 64'(xfers), 64'(NB + EXTRA));
  endtask

  task automatic wait_xfers(input int n);
    int guard;
    guard = 0;
    while (xfers < n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("wait_xfers_timeout", 64'(xfers >= n), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NW-1:0] ramp, v;
    int t0, dc;
    logic [7:0] got16[$];
    int d16;
    logic [7:0] x16;

    for (int k = 0; k < NB; k++) ramp[8*k +: 8] = 8'(k);

    // Reset state
    idle(3);
    #1;
    check("rst_valid", 64'(tx_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_data", 64'(tx_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Ramp nonce, always ready
    start_msg(ramp, 0, t0);
    finish_msg(t0, 1'b1);
    idle(3);

    // Ramp nonce, ready toggling 1,0,0,1
    start_msg(ramp, 1, t0);
    finish_msg(t0, 1'b0);
    idle(3);

    // Re-send during byte 5 is ignored
    dc = done_cnt;
    start_msg(ramp, 0, t0);
    wait_xfers(5);
    @(posedge clk);
    #2;
    send  = 1'b1;
    nonce = ~ramp;
    @(posedge clk);
    #2;
    send  = 1'b0;
    check("resend_still_busy", 64'(busy), 64'd1);
    finish_msg(t0, 1'b1);
    idle(5);
    check("resend_single_done", 64'(done_cnt - dc), 64'd1);

    // Reset at byte 10 aborts the message
    start_msg(ramp, 0, t0);
    wait_xfers(10);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid_low", 64'(tx_valid), 64'd0);
    check("abort_busy_low", 64'(busy), 64'd0);
    exp_q.delete();
    done_pending = 1'b0;
    dc = done_cnt;
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    #1;
    check("abort_no_done", 64'(done_cnt - dc), 64'd0);
    check("abort_data_clear", 64'(tx_data), 64'd0);
    start_msg({NW{1'b1}}, 0, t0);
    finish_msg(t0, 1'b1);
    idle(2);

    // Single nonzero low byte (checksum equals it when enabled)
    v = '0;
    v[7:0] = 8'hAB;
    start_msg(v, 1, t0);
    finish_msg(t0, 1'b0);
    idle(2);

    // Random nonces, random back-pressure
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < NW / 32; w++) v[32*w +: 32] = $urandom();
      start_msg(v, 2, t0);
      finish_msg(t0, 1'b0);
      idle(int'($urandom_range(0, 3)));
    end
    ready_mode = 0;

    // 16-bit instance: 0xBEEF
    @(posedge clk);
    #2;
    send16  = 1'b1;
    nonce16 = 16'hBEEF;
    t0 = cyc;
    d16 = -1;
    @(posedge clk);
    #2;
    send16  = 1'b0;
    nonce16 = 16'h1234;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid16 && ready16) got16.push_back(data16);
      if (done16 && d16 < 0) d16 = cyc - t0;
    end
    check("w16_count", 64'(got16.size()), 64'(2 + EXTRA));
    if (got16.size() >= 2) begin
      check("w16_byte0", 64'(got16[0]), 64'hEF);
      check("w16_byte1", 64'(got16[1]), 64'hBE);
    end
    if (EXTRA == 1 && got16.size() >= 3) begin
      x16 = 8'hEF ^ 8'hBE;
      check("w16_csum", 64'(got16[2]), 64'(x16));
    end
    check("w16_done_latency", 64'(d16), 64'(4 + EXTRA));

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nonce_transmitter.md
Name: nonce_transmitter

Overview:
- Serializes a captured nonce into a byte stream for the UART transmit path. This is the return direction of the byte-wise nonce load, which shifts bytes in LSB first.
- Bytes leave least-significant first, so a nonce echoed back over the link reassembles identically on the host.
- Sits between the search core's best-nonce output and the UART TX byte interface.
- Uses a valid/ready byte handshake and gives a one-cycle completion strobe.

Parameters:
- NONCE_WIDTH, 256, nonce width in bits; must be a multiple of 8 and at least 8.
- NUM_BYTES, NONCE_WIDTH/8, derived constant (localparam); not overridable.

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- send_i  input  1  request: capture nonce_i and start transmission; sampled only in IDLE.
- nonce_i  input  NONCE_WIDTH  nonce to transmit; sampled in the cycle send_i is accepted.
- tx_ready_i  input  1  downstream UART can accept a byte this cycle.
- tx_valid_o  output  1  tx_data_o holds a valid byte.
- tx_data_o  output  8  byte being offered.
- busy_o  output  1  high from the capture cycle until the last byte is accepted.
- done_o  output  1  one-cycle strobe after the final byte transfers.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State = IDLE; shift register, byte counter and tx_data_o = 0.
  - tx_valid_o = 0, busy_o = 0, done_o = 0.
- States: IDLE, SEND, DONE.
- IDLE:
  - If send_i = 1: load nonce_i into the shift register, clear the counter, go to SEND.
  - busy_o rises in the cycle after send_i.
  - tx_valid_o rises with byte 0 (nonce_i[7:0]) in the cycle after send_i, so latency from send_i to first valid is 1 cycle.
- SEND:
  - tx_valid_o = 1 and tx_data_o = shift[7:0].
  - A transfer occurs when tx_valid_o and tx_ready_i are both high in the same cycle.
  - On a transfer, the shift register shifts right 8 bits (zero-filled) and the counter increments.
  - If tx_ready_i = 0, hold tx_data_o and tx_valid_o stable (no bubbles, no data change while stalled).
  - When the byte with counter index NUM_BYTES-1 transfers, go to DONE; tx_valid_o drops the next cycle.
  - Back-to-back transfers are allowed: one byte per cycle while tx_ready_i stays high.
- DONE:
  - done_o = 1 and busy_o = 0 for exactly one cycle, then return to IDLE.
- send_i while in SEND or DONE is ignored: no re-capture, no queuing.
- nonce_i changes after capture have no effect on the bytes being sent.
- Counter width is clog2(NUM_BYTES+1); it never wraps within a message.
- Minimum message time is NUM_BYTES+2 cycles from send_i to done_o (32 bytes -> done_o 34 cycles after send_i, with tx_ready_i held at 1).
- Reset mid-message aborts the message immediately:
  - tx_valid_o goes low asynchronously.
  - No done_o is issued.
  - The next send_i starts a fresh message from byte 0.

Optional Feature:
- Macro: NONCE_TX_CHECKSUM_EN
- Defined:
  - After the last nonce byte, the block sends one extra byte: the XOR of all NUM_BYTES nonce bytes.
  - The checksum accumulates as each byte transfers and resets to 0 on capture.
  - The checksum byte uses the same valid/ready handshake.
  - done_o follows the checksum byte's transfer.
  - Total bytes sent = NUM_BYTES+1.
- Undefined:
  - No checksum logic is present.
  - Exactly NUM_BYTES bytes are sent.

Test Plan:
- Reset release, tx_ready_i=1, send_i pulse with nonce_i = 0x1F1E..0100 (byte k = k) -> tx_data_o sequence 0x00, 0x01 .. 0x1F on 32 consecutive cycles; done_o pulses once, 34 cycles after send_i.
- Same nonce, tx_ready_i toggling 1,0,0,1 repeating -> each byte held stable while stalled; no byte duplicated or dropped; 32 transfers total.
- send_i re-asserted at byte 5 with a different nonce_i -> ignored; original bytes continue; only one done_o.
- rst_n_i pulsed low at byte 10 -> tx_valid_o=0 immediately, no done_o; a subsequent send_i of all-0xFF gives 32 bytes of 0xFF starting from byte 0.
- NONCE_TX_CHECKSUM_EN defined, nonce byte k = k -> 33 bytes sent; 33rd byte = 0x00 (XOR of 0..31); with nonce = 0x...0000AB (all other bytes zero) the checksum byte = 0xAB.
- NONCE_WIDTH=16, nonce_i = 0xBEEF -> bytes 0xEF, 0xBE; done_o 4 cycles after send_i.
